// File: rtl/alu_pkg.sv
// Shared op encodings and helpers for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_RCL   = 3'b101;
    localparam logic [2:0] OP_RCR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD   = OP_ADD,
        ALU_SUB   = OP_SUB,
        ALU_AND   = OP_AND,
        ALU_OR    = OP_OR,
        ALU_XOR   = OP_XOR,
        ALU_RCL   = OP_RCL,
        ALU_RCR   = OP_RCR,
        ALU_PASSB = OP_PASSB
    } alu_op_e;

    // Only the carry-producing ops feed the persistent carry register.
    function automatic logic op_updates_cc(alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_RCL) || (op == ALU_RCR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; flag outputs exist only when ALU_FLAGS_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             cin_i,
`ifdef ALU_FLAGS_EN
    output logic             zf_o,
    output logic             nf_o,
    output logic             vf_o,
`endif
    output logic [WIDTH-1:0] d_o,
    output logic             co_o
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [WIDTH:0]   cin_ext;

    assign cin_ext = {{WIDTH{1'b0}}, cin_i};

    always_comb begin
        wide  = '0;
        res   = '0;
        carry = 1'b0;
        case (alu_op_e'(op_i))
            ALU_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i} + cin_ext;
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            // Bit WIDTH of the extended difference is set exactly when a < b + cin.
            ALU_SUB: begin
                wide  = {1'b0, a_i} - {1'b0, b_i} - cin_ext;
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            ALU_AND:   res = a_i & b_i;
            ALU_OR:    res = a_i | b_i;
            ALU_XOR:   res = a_i ^ b_i;
            ALU_RCL: begin
                res   = {a_i[WIDTH-2:0], cin_i};
                carry = a_i[WIDTH-1];
            end
            ALU_RCR: begin
                res   = {cin_i, a_i[WIDTH-1:1]};
                carry = a_i[0];
            end
            ALU_PASSB: res = b_i;
            default:   res = '0;
        endcase
    end

    assign d_o  = res;
    assign co_o = carry;

`ifdef ALU_FLAGS_EN
    always_comb begin
        vf_o = 1'b0;
        if (alu_op_e'(op_i) == ALU_ADD)
            vf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
        else if (alu_op_e'(op_i) == ALU_SUB)
            vf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
    end

    assign zf_o = (res == '0);
    assign nf_o = res[WIDTH-1];
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a persistent carry register for chained multi-word ops.
// Optional zf/nf/vf flag outputs are built when ALU_FLAGS_EN is defined.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       f_i,
    input  logic             cci_i,
    input  logic             use_cc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             co_o,
`ifdef ALU_FLAGS_EN
    output logic             zf_o,
    output logic             nf_o,
    output logic             vf_o,
`endif
    output logic             cc_o
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    alu_op_e          s1_op_q, s1_op_d;
    logic             s1_cci_q, s1_cci_d;
    logic             s1_use_cc_q, s1_use_cc_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             co_q, co_d;
    logic             cc_q, cc_d;

    logic             s2_adv, s1_adv, in_ready;
    logic             cin;
    logic [WIDTH-1:0] core_d;
    logic             core_co;

    assign s2_adv   = !s2_valid_q || out_ready_i;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;

    // cc already reflects the previous beat when this one leaves S1, so chains need no stall.
    assign cin = s1_use_cc_q ? cc_q : s1_cci_q;

`ifdef ALU_FLAGS_EN
    logic core_zf, core_nf, core_vf;
    logic zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .op_i  (s1_op_q),
        .cin_i (cin),
`ifdef ALU_FLAGS_EN
        .zf_o  (core_zf),
        .nf_o  (core_nf),
        .vf_o  (core_vf),
`endif
        .d_o   (core_d),
        .co_o  (core_co)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_cci_d    = s1_cci_q;
        s1_use_cc_d = s1_use_cc_q;
        if (in_ready) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_a_d      = a_i;
                s1_b_d      = b_i;
                s1_op_d     = alu_op_e'(f_i);
                s1_cci_d    = cci_i;
                s1_use_cc_d = use_cc_i;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        co_d       = co_q;
        cc_d       = cc_q;
        if (s2_adv)
            s2_valid_d = s1_valid_q;
        if (s1_adv) begin
            d_d  = core_d;
            co_d = core_co;
            if (op_updates_cc(s1_op_q))
                cc_d = core_co;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= ALU_ADD;
            s1_cci_q    <= 1'b0;
            s1_use_cc_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            d_q         <= '0;
            co_q        <= 1'b0;
            cc_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_cci_q    <= s1_cci_d;
            s1_use_cc_q <= s1_use_cc_d;
            s2_valid_q  <= s2_valid_d;
            d_q         <= d_d;
            co_q        <= co_d;
            cc_q        <= cc_d;
        end
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        zf_d = zf_q;
        nf_d = nf_q;
        vf_d = vf_q;
        if (s1_adv) begin
            zf_d = core_zf;
            nf_d = core_nf;
            vf_d = core_vf;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
            vf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            nf_q <= nf_d;
            vf_q <= vf_d;
        end
    end

    assign zf_o = zf_q;
    assign nf_o = nf_q;
    assign vf_o = vf_q;
`endif

    assign in_ready_o  = in_ready;
    assign out_valid_o = s2_valid_q;
    assign d_o         = d_q;
    assign co_o        = co_q;
    assign cc_o        = cc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=8) with immediate-assertion checks.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [2:0] f;
    logic       cci, use_cc;
    logic       out_valid, out_ready;
    logic [7:0] d;
    logic       co, cc;
`ifdef ALU_FLAGS_EN
    logic       zf, nf, vf;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, OR_ = 3'b011, XOR_ = 3'b100;
    localparam logic [2:0] RCL = 3'b101, RCR = 3'b110, PASSB = 3'b111;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .f_i         (f),
        .cci_i       (cci),
        .use_cc_i    (use_cc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .d_o         (d),
        .co_o        (co),
`ifdef ALU_FLAGS_EN
        .zf_o        (zf),
        .nf_o        (nf),
        .vf_o        (vf),
`endif
        .cc_o        (cc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic uc);
        in_valid = 1'b1;
        f        = op;
        a        = av;
        b        = bv;
        cci      = ci;
        use_cc   = uc;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; f = '0;
        cci = 1'b0; use_cc = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d", d, 0);
        chk("rst_co", co, 0);
        chk("rst_cc", cc, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Single ADD with carry-out; out_valid must pulse for exactly one cycle
        step();
        beat(ADD, 8'hF0, 8'h20, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("add_latency_ov", out_valid, 0);
        step();
        chk("add_ov", out_valid, 1);
        chk("add_d", d, 8'h10);
        chk("add_co", co, 1);
        chk("add_cc", cc, 1);
        step();
        chk("add_ov_pulse", out_valid, 0);

        // Chained 16-bit add, back to back
        beat(ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("chain_rdy0", in_ready, 1);
        step();
        beat(ADD, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("chain_rdy1", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("chain_lo_ov", out_valid, 1);
        chk("chain_lo_d", d, 8'h00);
        chk("chain_lo_co", co, 1);
        step();
        chk("chain_hi_ov", out_valid, 1);
        chk("chain_hi_d", d, 8'h01);
        chk("chain_hi_co", co, 0);
        chk("chain_hi_cc", cc, 0);

        // SUB with borrow, then XOR leaves cc alone
        beat(SUB, 8'h05, 8'h07, 1'b0, 1'b0);
        step();
        beat(XOR_, 8'hAA, 8'h0F, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("sub_d", d, 8'hFE);
        chk("sub_co", co, 1);
        step();
        chk("xor_d", d, 8'hA5);
        chk("xor_co", co, 0);
        chk("xor_cc", cc, 1);

        // Rotates through carry
        beat(RCL, 8'h81, 8'h00, 1'b0, 1'b1);
        step();
        beat(RCR, 8'h01, 8'h00, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("rcl_d", d, 8'h03);
        chk("rcl_co", co, 1);
        step();
        chk("rcr_d", d, 8'h00);
        chk("rcr_co", co, 1);
        chk("rcr_cc", cc, 1);
        step();

        // Backpressure: 4 beats with out_ready low
        out_ready = 1'b0;
        beat(ADD, 8'h01, 8'h01, 1'b0, 1'b0);
        chk("bp_rdy0", in_ready, 1);
        step();
        beat(ADD, 8'h10, 8'h01, 1'b0, 1'b0);
        chk("bp_rdy1", in_ready, 1);
        step();
        beat(PASSB, 8'h00, 8'h5A, 1'b0, 1'b0);
        chk("bp_rdy_full", in_ready, 0);
        chk("bp_ov", out_valid, 1);
        chk("bp_d0", d, 8'h02);
        step();
        chk("bp_rdy_held", in_ready, 0);
        chk("bp_d_stable", d, 8'h02);
        chk("bp_co_stable", co, 0);
        chk("bp_cc", cc, 0);
        out_ready = 1'b1;
        #1 chk("bp_rdy_release", in_ready, 1);
        step();
        beat(OR_, 8'h30, 8'h03, 1'b0, 1'b0);
        chk("bp_d1_ov", out_valid, 1);
        chk("bp_d1", d, 8'h11);
        step();
        in_valid = 1'b0;
        chk("bp_d2", d, 8'h5A);
        step();
        chk("bp_d3_ov", out_valid, 1);
        chk("bp_d3", d, 8'h33);
        step();
        chk("bp_drained", out_valid, 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        beat(ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        step();
        beat(ADD, 8'h01, 8'h02, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("inflight_ov", out_valid, 1);
        chk("inflight_cc", cc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ov", out_valid, 0);
        chk("async_rst_cc", cc, 0);
        chk("async_rst_d", d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        beat(ADD, 8'h12, 8'h34, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        chk("post_rst_ov0", out_valid, 0);
        step();
        chk("post_rst_ov", out_valid, 1);
        chk("post_rst_d", d, 8'h47);
        chk("post_rst_co", co, 0);
        step();

`ifdef ALU_FLAGS_EN
        beat(ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("flag_d", d, 8'h80);
        chk("flag_vf", vf, 1);
        chk("flag_nf", nf, 1);
        chk("flag_zf", zf, 0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 4-bit combinational ALU. It accepts WIDTH-bit operand pairs over a valid/ready handshake and computes one of eight operations. Results return after two register stages with carry-out. A persistent carry register lets multi-word add, subtract and shift sequences chain without external carry plumbing. It sits between the datapath sequencer and the writeback stage.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- f  in  3  operation select (alu_op_e)
- cci  in  1  external carry/borrow in
- use_cc  in  1  1: carry-in taken from internal carry register; 0: from cci
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- d  out  WIDTH  result
- co  out  1  carry/borrow out of this beat
- cc  out  1  current internal carry register value

## Operation
- Operations, cin = use_cc ? cc : cci:
  - 000 ADD: {co,d} = a + b + cin.
  - 001 SUB: d = a − b − cin, modulo 2^WIDTH; co = 1 iff a < b + cin (borrow).
  - 010 AND, 011 OR, 100 XOR: bitwise; co = 0.
  - 101 RCL: d = {a[WIDTH-2:0], cin}; co = a[WIDTH-1].
  - 110 RCR: d = {cin, a[WIDTH-1:1]}; co = a[0].
  - 111 PASSB: d = b; co = 0.
- Arithmetic is unsigned WIDTH+1-bit; no saturation.
- Stage 1 (S1) registers a, b, f and the resolved operand flags.
- The computation is combinational from S1 into stage 2 (S2). S2 registers d and co.
- cc is updated with co when a beat moves S1→S2, for ADD, SUB, RCL and RCR only. Logic ops and PASSB leave cc unchanged.
- cin for a beat is sampled when that beat moves S1→S2. The previous beat has then already updated cc, so back-to-back chained beats need no stall.
- Reset values: in_ready 1 (after reset release), out_valid 0, d 0, co 0, cc 0, all stage valids 0.

## Timing
- Accept on the rising edge where in_valid && in_ready. The result is on d/co with out_valid high 2 cycles later if there is no backpressure.
- Throughput: 1 beat/cycle.
- Advance rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when s1_valid && S2 can advance.
  - in_ready = !s1_valid || S1 advances. This is a combinational path from out_ready; no skid buffer.
- While out_valid && !out_ready, d, co, flags and cc are held stable, and at most 2 beats are in flight.
- If in_valid drops mid-stream, bubbles propagate; out_valid deasserts for those cycles.
- Reset asserted mid-operation: both stages are emptied, in-flight beats are discarded, cc = 0, and the outputs take their reset values asynchronously.

## Configuration
- ALU_FLAGS_EN defined:
  - Adds outputs zf (d == 0), nf (d[WIDTH-1]) and vf, all registered in S2 alongside d.
  - vf is signed overflow: for ADD, a and b have equal MSBs and d's MSB differs; for SUB, a and b have differing MSBs and d's MSB differs from a's. vf = 0 for all other ops.
  - Flags reset to 0.
- ALU_FLAGS_EN undefined: the zf, nf and vf ports and their logic are absent; everything else is identical.

## Structure
- alu_pkg: alu_op_e enum (3-bit, codes above) and localparams for the op encodings.
- Sub-module alu_core: purely combinational, parametrised by WIDTH. Inputs a, b, op, cin; outputs d and co (plus flags under ALU_FLAGS_EN).
- alu_pipe instantiates alu_core between S1 and S2 and owns the handshake and cc register.

## Test plan (WIDTH=8)
- Reset, then ADD a=8'hF0, b=8'h20, cci=0, use_cc=0, out_ready=1 → 2 cycles later d=8'h10, co=1, cc=1, out_valid pulse of 1 cycle.
- Chained 16-bit add: beat 1 ADD 8'hFF+8'h01 with use_cc=0, then beat 2 back-to-back ADD 8'h00+8'h00 with use_cc=1 → d=8'h00, co=1, then d=8'h01, co=0; no stall cycles.
- SUB a=8'h05, b=8'h07, cci=0 → d=8'hFE, co=1. Then XOR 8'hAA^8'h0F → d=8'hA5, co=0, cc still 1.
- Backpressure: hold out_ready=0 while streaming 4 beats → in_ready falls after 2 accepted; d stable. Release → remaining beats delivered in order, none lost or duplicated.
- RCL a=8'h81 with use_cc=1, cc=1 → d=8'h03, co=1. RCR a=8'h01, cin=0 → d=8'h00, co=1.
- Assert rst_n low with 2 beats in flight → out_valid=0, cc=0 immediately. After release the first new beat returns a correct result. With ALU_FLAGS_EN: ADD 8'h7F+8'h01 → vf=1, nf=1, zf=0.
